// File: rtl/hmc_tx_sched_pkg.sv
// Shared types and helpers for the HMC TX token scheduler.
//   sched_state_t : scheduler FSM states, also reported to the register file
//   flit_len_t    : packet length in FLITs as carried by each requester
//   legalize_len  : maps an out-of-range length onto the largest legal packet
//   len_is_illegal: flags lengths that must be reported through len_err
package hmc_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sched_state_t;

  localparam int FLIT_LEN_W    = 4;
  localparam int MAX_PKT_FLITS = 9;

  typedef logic [FLIT_LEN_W-1:0] flit_len_t;

  // A zero length or anything longer than the largest packet is illegal.
  function automatic logic len_is_illegal(input flit_len_t len, input flit_len_t max_len);
    return (len == '0) || (len > max_len);
  endfunction

  // Illegal lengths are charged as the largest packet so the credit count
  // never under-reserves space in the HMC input buffer.
  function automatic flit_len_t legalize_len(input flit_len_t len, input flit_len_t max_len);
    return len_is_illegal(len, max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Rotating-priority first-one finder.
//   valid   : request vector
//   pointer : highest-priority position this cycle
//   onehot  : one-hot of the first valid bit at/after pointer (wrapping)
//   idx     : index of that bit
//   found   : at least one valid bit exists
module rr_prio_select #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]     valid,
  input  logic [LOG_NUM_REQ-1:0] pointer,
  output logic [NUM_REQ-1:0]     onehot,
  output logic [LOG_NUM_REQ-1:0] idx,
  output logic                   found
);

  int pos;

  // Walk the requesters starting at the pointer; the first valid one wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = (int'(pointer) + i) % NUM_REQ;
      if (!found && valid[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos[LOG_NUM_REQ-1:0];
      end
    end
  end

endmodule

// File: rtl/hmc_tx_token_scheduler.sv
// HMC TX token scheduler.
// Shares the TX link among NUM_REQ packet sources. One whole packet is granted
// per cycle in round-robin order, but only while enough HMC input-buffer tokens
// remain. Grants debit the token counter; RTC returns from the RX path credit it.
//   clk_hmc, rst      : link clock, synchronous active-high reset
//   rf_hmc_tokens     : initial/max credit, loaded by the rf_tokens_load pulse
//   tx_enable         : link up; grants only while high
//   req_valid/flits   : per-requester pending packet and its length
//   req_ready         : combinational one-hot grant
//   grant_valid/idx/flits : registered copy of the grant (one cycle later)
//   tok_return        : tokens returned this cycle
//   tokens_avail      : current credit
//   tok_overflow_err  : sticky, credit would have exceeded the loaded max
//   len_err           : sticky, a granted packet had an illegal length
//   sched_state       : FSM state for status readout
module hmc_tx_token_scheduler #(
  parameter int NUM_REQ            = 4,
  parameter int LOG_NUM_REQ        = 2,
  parameter int LOG_MAX_HMC_TOKENS = 10,
  parameter int MAX_PKT_FLITS      = hmc_tx_sched_pkg::MAX_PKT_FLITS
) (
  input  logic                          clk_hmc,
  input  logic                          rst,
  input  logic [LOG_MAX_HMC_TOKENS-1:0] rf_hmc_tokens,
  input  logic                          rf_tokens_load,
  input  logic                          tx_enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*4-1:0]          req_flits,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          grant_valid,
  output logic [LOG_NUM_REQ-1:0]        grant_idx,
  output logic [3:0]                    grant_flits,
  input  logic [LOG_MAX_HMC_TOKENS-1:0] tok_return,
  output logic [LOG_MAX_HMC_TOKENS-1:0] tokens_avail,
  output logic                          tok_overflow_err,
  output logic                          len_err,
  output logic [1:0]                    sched_state
);

  import hmc_tx_sched_pkg::*;

  localparam int        TW      = LOG_MAX_HMC_TOKENS;
  localparam flit_len_t MAX_LEN = flit_len_t'(MAX_PKT_FLITS);

  sched_state_t           state;
  logic [TW-1:0]          tokens;
  logic [TW-1:0]          tok_max;
  logic [LOG_NUM_REQ-1:0] rr_ptr;

  logic [NUM_REQ-1:0]     sel_onehot;
  logic [LOG_NUM_REQ-1:0] sel_idx;
  logic                   sel_found;

  flit_len_t              cand_raw;
  flit_len_t              cand_len;
  flit_len_t              debit;
  logic                   grant;
  logic [TW:0]            tok_next_wide;
  logic                   tok_over;

  rr_prio_select #(
    .NUM_REQ    (NUM_REQ),
    .LOG_NUM_REQ(LOG_NUM_REQ)
  ) u_sel (
    .valid  (req_valid),
    .pointer(rr_ptr),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .found  (sel_found)
  );

  // Grant decision. Only the round-robin candidate is considered: if it does
  // not fit in the remaining credit nobody is granted, so long packets cannot
  // be starved by a stream of short ones. Reset and a dropping tx_enable both
  // suppress the grant in the same cycle.
  // The token update is computed one bit wider so the sum of credit and
  // return can be compared against the max without wrapping.
  always_comb begin
    cand_raw      = req_flits[FLIT_LEN_W*sel_idx +: FLIT_LEN_W];
    cand_len      = legalize_len(cand_raw, MAX_LEN);
    grant         = !rst && (state == RUN) && tx_enable && sel_found &&
                    ({{(TW-FLIT_LEN_W){1'b0}}, cand_len} <= tokens);
    req_ready     = grant ? sel_onehot : '0;
    debit         = grant ? cand_len : '0;
    tok_next_wide = {1'b0, tokens} - {{(TW+1-FLIT_LEN_W){1'b0}}, debit} + {1'b0, tok_return};
    tok_over      = tok_next_wide > {1'b0, tok_max};
  end

  // FSM, token counter, round-robin pointer and grant register.
  // A register-file load overrides any debit or return in the same cycle;
  // a grant issued alongside it still goes out, only its debit is lost.
  always_ff @(posedge clk_hmc) begin
    if (rst) begin
      state            <= IDLE;
      tokens           <= '0;
      tok_max          <= '0;
      rr_ptr           <= '0;
      grant_valid      <= 1'b0;
      grant_idx        <= '0;
      grant_flits      <= '0;
      tok_overflow_err <= 1'b0;
      len_err          <= 1'b0;
    end else begin
      grant_valid <= grant;
      grant_idx   <= grant ? sel_idx : '0;
      grant_flits <= debit;
      if (grant) begin
        rr_ptr <= (sel_idx == LOG_NUM_REQ'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (rf_tokens_load) begin
            tokens           <= rf_hmc_tokens;
            tok_max          <= rf_hmc_tokens;
            tok_overflow_err <= 1'b0;
            len_err          <= 1'b0;
            state            <= tx_enable ? RUN : PAUSE;
          end
        end
        RUN, PAUSE: begin
          if (rf_tokens_load) begin
            tokens           <= rf_hmc_tokens;
            tok_max          <= rf_hmc_tokens;
            tok_overflow_err <= 1'b0;
            len_err          <= 1'b0;
          end else begin
            tokens <= tok_over ? tok_max : tok_next_wide[TW-1:0];
            if (tok_over) begin
              tok_overflow_err <= 1'b1;
            end
            if (grant && len_is_illegal(cand_raw, MAX_LEN)) begin
              len_err <= 1'b1;
            end
          end
          state <= tx_enable ? RUN : PAUSE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tokens_avail = tokens;
  assign sched_state  = state;

endmodule

// File: tb/tb_hmc_tx_token_scheduler.sv
module tb_hmc_tx_token_scheduler;

  logic        clk_hmc;
  logic        rst;
  logic [9:0]  rf_hmc_tokens;
  logic        rf_tokens_load;
  logic        tx_enable;
  logic [3:0]  req_valid;
  logic [15:0] req_flits;
  logic [3:0]  req_ready;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [3:0]  grant_flits;
  logic [9:0]  tok_return;
  logic [9:0]  tokens_avail;
  logic        tok_overflow_err;
  logic        len_err;
  logic [1:0]  sched_state;

  int tests_run;
  int tests_failed;

  hmc_tx_token_scheduler dut (
    .clk_hmc         (clk_hmc),
    .rst             (rst),
    .rf_hmc_tokens   (rf_hmc_tokens),
    .rf_tokens_load  (rf_tokens_load),
    .tx_enable       (tx_enable),
    .req_valid       (req_valid),
    .req_flits       (req_flits),
    .req_ready       (req_ready),
    .grant_valid     (grant_valid),
    .grant_idx       (grant_idx),
    .grant_flits     (grant_flits),
    .tok_return      (tok_return),
    .tokens_avail    (tokens_avail),
    .tok_overflow_err(tok_overflow_err),
    .len_err         (len_err),
    .sched_state     (sched_state)
  );

  initial clk_hmc = 1'b0;
  always #5 clk_hmc = ~clk_hmc;

  task automatic cycle();
    @(posedge clk_hmc);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic load_tokens(input logic [9:0] n);
    rf_hmc_tokens  = n;
    rf_tokens_load = 1'b1;
    cycle();
    rf_tokens_load = 1'b0;
  endtask

  task automatic test_reset();
    req_valid  = 4'b1111;
    req_flits  = {4'd1, 4'd1, 4'd1, 4'd1};
    tx_enable  = 1'b1;
    do_reset();
    tests_run++;
    if (sched_state !== 2'd0) begin
      tests_failed++; $display("[TB] FAIL reset_state: got %0d expected 0", sched_state);
    end
    tests_run++;
    if (tokens_avail !== 10'd0) begin
      tests_failed++; $display("[TB] FAIL reset_tokens: got %0d expected 0", tokens_avail);
    end
    tests_run++;
    if ({grant_valid, grant_idx, grant_flits, tok_overflow_err, len_err} !== 9'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got gv=%0d gi=%0d gf=%0d ovf=%0d lerr=%0d expected all 0",
               grant_valid, grant_idx, grant_flits, tok_overflow_err, len_err);
    end
    tok_return = 10'd5;
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL idle_ready: got %b expected 0000", req_ready);
    end
    cycle();
    tests_run++;
    if (tokens_avail !== 10'd0) begin
      tests_failed++; $display("[TB] FAIL idle_ignores_return: got %0d expected 0", tokens_avail);
    end
    tok_return = 10'd0;
    req_valid  = 4'b0000;
  endtask

  task automatic test_credit_block();
    tx_enable = 1'b1;
    load_tokens(10'd16);
    tests_run++;
    if (sched_state !== 2'd1 || tokens_avail !== 10'd16) begin
      tests_failed++;
      $display("[TB] FAIL load_to_run: got state=%0d tokens=%0d expected state=1 tokens=16", sched_state, tokens_avail);
    end
    req_valid = 4'b0011;
    req_flits = {4'd0, 4'd0, 4'd9, 4'd9};
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++; $display("[TB] FAIL t1_ready0: got %b expected 0001", req_ready);
    end
    cycle();
    tests_run++;
    if (tokens_avail !== 10'd7 || grant_valid !== 1'b1 || grant_idx !== 2'd0 || grant_flits !== 4'd9) begin
      tests_failed++;
      $display("[TB] FAIL t1_grant0: got tok=%0d gv=%0d gi=%0d gf=%0d expected 7 1 0 9",
               tokens_avail, grant_valid, grant_idx, grant_flits);
    end
    req_valid = 4'b0010;
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL t1_blocked: got %b expected 0000", req_ready);
    end
    cycle();
    tests_run++;
    if (grant_valid !== 1'b0 || tokens_avail !== 10'd7) begin
      tests_failed++; $display("[TB] FAIL t1_no_debit: got gv=%0d tok=%0d expected 0 7", grant_valid, tokens_avail);
    end
    tok_return = 10'd2;
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL t1_return_cycle_ready: got %b expected 0000", req_ready);
    end
    cycle();
    tok_return = 10'd0;
    tests_run++;
    if (tokens_avail !== 10'd9) begin
      tests_failed++; $display("[TB] FAIL t1_return: got %0d expected 9", tokens_avail);
    end
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++; $display("[TB] FAIL t1_ready1: got %b expected 0010", req_ready);
    end
    cycle();
    req_valid = 4'b0000;
    tests_run++;
    if (tokens_avail !== 10'd0 || grant_valid !== 1'b1 || grant_idx !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL t1_grant1: got tok=%0d gv=%0d gi=%0d expected 0 1 1", tokens_avail, grant_valid, grant_idx);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_idx;
    do_reset();
    tx_enable = 1'b1;
    load_tokens(10'd100);
    req_valid = 4'b1111;
    req_flits = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int k = 0; k < 5; k++) begin
      exp_idx = 2'(k % 4);
      @(negedge clk_hmc);
      tests_run++;
      if (req_ready !== (4'b0001 << exp_idx)) begin
        tests_failed++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'b0001 << exp_idx);
      end
      if (k == 0) begin
        tests_run++;
        if (grant_valid !== 1'b0) begin
          tests_failed++; $display("[TB] FAIL rr_latency: got gv=%0d expected 0", grant_valid);
        end
      end
      cycle();
      tests_run++;
      if (grant_valid !== 1'b1 || grant_idx !== exp_idx || grant_flits !== 4'd1 || tokens_avail !== 10'(99 - k)) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant[%0d]: got gv=%0d gi=%0d gf=%0d tok=%0d expected 1 %0d 1 %0d",
                 k, grant_valid, grant_idx, grant_flits, tokens_avail, exp_idx, 99 - k);
      end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_no_bypass();
    do_reset();
    tx_enable = 1'b1;
    load_tokens(10'd15);
    req_flits = {4'd1, 4'd9, 4'd1, 4'd9};
    req_valid = 4'b0011;
    cycle();
    req_valid = 4'b0010;
    cycle();
    tests_run++;
    if (tokens_avail !== 10'd5 || grant_idx !== 2'd1) begin
      tests_failed++; $display("[TB] FAIL nb_setup: got tok=%0d gi=%0d expected 5 1", tokens_avail, grant_idx);
    end
    req_valid = 4'b1100;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_hmc);
      tests_run++;
      if (req_ready !== 4'b0000) begin
        tests_failed++; $display("[TB] FAIL nb_no_bypass[%0d]: got %b expected 0000", k, req_ready);
      end
      cycle();
    end
    tok_return = 10'd4;
    cycle();
    tok_return = 10'd0;
    tests_run++;
    if (tokens_avail !== 10'd9) begin
      tests_failed++; $display("[TB] FAIL nb_return: got %0d expected 9", tokens_avail);
    end
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++; $display("[TB] FAIL nb_ready2: got %b expected 0100", req_ready);
    end
    cycle();
    req_valid = 4'b0000;
    tests_run++;
    if (tokens_avail !== 10'd0 || grant_idx !== 2'd2 || grant_flits !== 4'd9) begin
      tests_failed++; $display("[TB] FAIL nb_grant2: got tok=%0d gi=%0d gf=%0d expected 0 2 9", tokens_avail, grant_idx, grant_flits);
    end
  endtask

  task automatic test_overflow();
    load_tokens(10'd10);
    tok_return = 10'd3;
    cycle();
    tok_return = 10'd0;
    tests_run++;
    if (tokens_avail !== 10'd10 || tok_overflow_err !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL ovf_clamp: got tok=%0d ovf=%0d expected 10 1", tokens_avail, tok_overflow_err);
    end
    cycle();
    tests_run++;
    if (tok_overflow_err !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL ovf_sticky: got %0d expected 1", tok_overflow_err);
    end
    load_tokens(10'd10);
    tests_run++;
    if (tok_overflow_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL ovf_clear: got %0d expected 0", tok_overflow_err);
    end
  endtask

  task automatic test_simultaneous_return();
    load_tokens(10'd8);
    req_flits  = {4'd0, 4'd0, 4'd0, 4'd4};
    req_valid  = 4'b0001;
    tok_return = 10'd4;
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++; $display("[TB] FAIL sim_ready: got %b expected 0001", req_ready);
    end
    cycle();
    tok_return = 10'd0;
    req_valid  = 4'b0000;
    tests_run++;
    if (tokens_avail !== 10'd8 || grant_flits !== 4'd4 || tok_overflow_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sim_tokens: got tok=%0d gf=%0d ovf=%0d expected 8 4 0", tokens_avail, grant_flits, tok_overflow_err);
    end
    load_tokens(10'd20);
    tests_run++;
    if (len_err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL len_err_pre: got %0d expected 0", len_err);
    end
    req_valid = 4'b0010;
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++; $display("[TB] FAIL len0_ready: got %b expected 0010", req_ready);
    end
    cycle();
    req_valid = 4'b0000;
    tests_run++;
    if (tokens_avail !== 10'd11 || grant_flits !== 4'd9 || len_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL len0_grant: got tok=%0d gf=%0d lerr=%0d expected 11 9 1", tokens_avail, grant_flits, len_err);
    end
  endtask

  task automatic test_pause_and_reset();
    req_flits = {4'd0, 4'd1, 4'd0, 4'd0};
    req_valid = 4'b0100;
    tx_enable = 1'b0;
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL drop_ready: got %b expected 0000", req_ready);
    end
    cycle();
    tests_run++;
    if (sched_state !== 2'd2 || grant_valid !== 1'b0 || tokens_avail !== 10'd11) begin
      tests_failed++;
      $display("[TB] FAIL pause_enter: got st=%0d gv=%0d tok=%0d expected 2 0 11", sched_state, grant_valid, tokens_avail);
    end
    tok_return = 10'd3;
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL pause_ready: got %b expected 0000", req_ready);
    end
    cycle();
    cycle();
    tok_return = 10'd0;
    tests_run++;
    if (tokens_avail !== 10'd17) begin
      tests_failed++; $display("[TB] FAIL pause_accum: got %0d expected 17", tokens_avail);
    end
    tx_enable = 1'b1;
    cycle();
    tests_run++;
    if (sched_state !== 2'd1) begin
      tests_failed++; $display("[TB] FAIL resume: got %0d expected 1", sched_state);
    end
    @(negedge clk_hmc);
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++; $display("[TB] FAIL resume_ready: got %b expected 0100", req_ready);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL rst_ready: got %b expected 0000", req_ready);
    end
    cycle();
    rst = 1'b0;
    tests_run++;
    if (sched_state !== 2'd0 || tokens_avail !== 10'd0 || grant_valid !== 1'b0 || grant_idx !== 2'd0 ||
        grant_flits !== 4'd0 || len_err !== 1'b0 || tok_overflow_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_run: got st=%0d tok=%0d gv=%0d gi=%0d gf=%0d lerr=%0d ovf=%0d expected all 0",
               sched_state, tokens_avail, grant_valid, grant_idx, grant_flits, len_err, tok_overflow_err);
    end
    #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL rst_idle_ready: got %b expected 0000", req_ready);
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    rf_hmc_tokens  = '0;
    rf_tokens_load = 1'b0;
    tx_enable      = 1'b0;
    req_valid      = '0;
    req_flits      = '0;
    tok_return     = '0;

    test_reset();
    test_credit_block();
    test_round_robin();
    test_no_bypass();
    test_overflow();
    test_simultaneous_return();
    test_pause_and_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
